// File: rtl/core_data_mem_responder_if.sv
// Load/store request and response bundle between the execution unit and the data memory.
// master: requester side (drives req_*, rsp_ready); slave: memory responder side.
interface core_data_mem_responder_if #(
  parameter int LIS_OP_WIDTH   = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
);
  logic                      req_valid;
  logic                      req_ready;
  logic [LIS_OP_WIDTH-1:0]   req_op;
  logic [MEM_ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/core_data_mem_responder.sv
// Data SRAM responder: one load/store at a time, byte-lane select, right-aligned load data.
// Ports: clk, rst (sync, active-high), bus (slave modport of core_data_mem_responder_if).
module core_data_mem_responder #(
  parameter int LIS_OP_WIDTH   = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  core_data_mem_responder_if.slave bus
);
  localparam int IW    = MEM_ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  typedef logic [LIS_OP_WIDTH-1:0] op_t;
  localparam op_t LIS_LB  = op_t'(0);
  localparam op_t LIS_LH  = op_t'(1);
  localparam op_t LIS_LW  = op_t'(2);
  localparam op_t LIS_LBU = op_t'(3);
  localparam op_t LIS_LHU = op_t'(4);
  localparam op_t LIS_SB  = op_t'(5);
  localparam op_t LIS_SH  = op_t'(6);
  localparam op_t LIS_SW  = op_t'(7);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_n;

  op_t                       op_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      mis_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  take;
  logic                  mis_in;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] wd;
  logic [3:0]            be;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
  logic [DATA_WIDTH-1:0] ld;
  logic                  we;

  assign bus.req_ready = (state == IDLE) & ~rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign take = bus.req_valid & bus.req_ready;

  always_comb begin
    mis_in = 1'b0;
    case (bus.req_op)
      LIS_LH, LIS_LHU, LIS_SH: mis_in = bus.req_addr[0];
      LIS_LW, LIS_SW:          mis_in = |bus.req_addr[1:0];
      default:                 mis_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (take) begin
      op_q    <= bus.req_op;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      mis_q   <= mis_in;
    end
  end

  assign idx  = addr_q[MEM_ADDR_WIDTH-1:2];
  assign word = mem[idx];

  always_comb begin
    bsel = word[7:0];
    case (addr_q[1:0])
      2'd0: bsel = word[7:0];
      2'd1: bsel = word[15:8];
      2'd2: bsel = word[23:16];
      2'd3: bsel = word[31:24];
      default: bsel = word[7:0];
    endcase
    hsel = addr_q[1] ? word[31:16] : word[15:0];
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be = 4'b0000;
    wd = wdata_q;
    ld = '0;
    case (op_q)
      LIS_SB: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      LIS_SH: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      LIS_SW:          be = 4'b1111;
      LIS_LB, LIS_LBU: ld = {24'b0, bsel};
      LIS_LH, LIS_LHU: ld = {16'b0, hsel};
      LIS_LW:          ld = word;
      default:         ld = '0;
    endcase
  end

  // rst blocks a store that is in ACCESS on the same edge.
  assign we = (state == ACCESS) & ~mis_q & ~rst;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      rdata_q <= mis_q ? '0 : ld;
      err_q   <= mis_q;
    end
  end
endmodule
